// File: rtl/dmem_bridge.sv
// Data-side memory responder: one bus transaction per load/store, pipeline stalled until it completes.
// Latency: request seen in IDLE, bus request the next cycle; best case 2 stall cycles, rd valid in DONE.
// Backpressure: holds dreq_* stable until addr_ok; stalls the pipeline until data_ok.

typedef logic [31:0] word_t;
typedef logic [2:0]  msize_t;
typedef logic [3:0]  strobe_t;

typedef struct packed {
  logic   valid;
  word_t  addr;
  msize_t size;
} mem_read_req;

typedef struct packed {
  logic    valid;
  word_t   addr;
  msize_t  size;
  word_t   data;
  strobe_t strobe;
} mem_write_req;

module dmem_bridge (
  input  logic         clk,
  input  logic         reset,
  input  mem_read_req  mread,
  input  mem_write_req mwrite,
  input  logic         advance,
  input  logic         flush,
  output logic [31:0]  rd,
  output logic         stall,
  output logic         dreq_valid,
  output logic         dreq_is_write,
  output logic [31:0]  dreq_addr,
  output logic [2:0]   dreq_size,
  output logic [3:0]   dreq_strobe,
  output logic [31:0]  dreq_data,
  input  logic         dresp_addr_ok,
  input  logic         dresp_data_ok,
  input  logic [31:0]  dresp_data
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_DRAIN} state_t;

  state_t  state_q, state_d;
  logic    is_write_q, is_write_d;
  word_t   addr_q, addr_d;
  msize_t  size_q, size_d;
  strobe_t strobe_q, strobe_d;
  word_t   data_q, data_d;
  word_t   rdata_q, rdata_d;
  logic    flush_pend_q, flush_pend_d;

  logic req;
  logic flush_seen;

  assign req        = mread.valid | mwrite.valid;
  // A flush in any ADDR cycle must still be honoured once addr_ok finally arrives.
  assign flush_seen = flush | flush_pend_q;

  // State and request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      strobe_q     <= strobe_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic; a flushed access still completes its bus handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req && !flush) state_d = S_ADDR;
      S_ADDR: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) state_d = flush_seen ? S_IDLE  : S_DONE;
          else               state_d = flush_seen ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (dresp_data_ok) state_d = flush ? S_IDLE : S_DONE;
        else if (flush)    state_d = S_DRAIN;
      end
      S_DONE:  if (advance || flush) state_d = S_IDLE;
      S_DRAIN: if (dresp_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch (write wins if both valid), pending flush and load-data capture
  always_comb begin
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    flush_pend_d = 1'b0;
    if (state_q == S_IDLE && req && !flush) begin
      if (mwrite.valid) begin
        is_write_d = 1'b1;
        addr_d     = mwrite.addr;
        size_d     = mwrite.size;
        strobe_d   = mwrite.strobe;
        data_d     = mwrite.data;
      end else begin
        is_write_d = 1'b0;
        addr_d     = mread.addr;
        size_d     = mread.size;
        strobe_d   = '0;
        data_d     = '0;
      end
    end
    if (state_q == S_ADDR) flush_pend_d = flush_seen & ~dresp_addr_ok;
    // rd is zero outside DONE, so a stale load never leaks to a later instruction.
    if (state_q != S_DONE && state_d == S_DONE)
      rdata_d = is_write_q ? '0 : dresp_data;
    else if (state_q == S_DONE && state_d == S_IDLE)
      rdata_d = '0;
  end

  // Outputs decoded from state and request registers
  always_comb begin
    dreq_valid    = (state_q == S_ADDR);
    dreq_is_write = is_write_q;
    dreq_addr     = addr_q;
    dreq_size     = size_q;
    dreq_strobe   = strobe_q;
    dreq_data     = data_q;
    rd            = rdata_q;
    case (state_q)
      S_IDLE:  stall = req & ~flush;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: loads, delayed store, freeze, flushes and mid-transaction reset.
// Inputs driven 1ns after posedge, outputs checked on the falling edge.
// The bench plays the bus slave by driving dresp_* explicitly per cycle.

module tb_dmem_bridge;

  logic         clk;
  logic         reset;
  mem_read_req  mread;
  mem_write_req mwrite;
  logic         advance;
  logic         flush;
  logic [31:0]  rd;
  logic         stall;
  logic         dreq_valid;
  logic         dreq_is_write;
  logic [31:0]  dreq_addr;
  logic [2:0]   dreq_size;
  logic [3:0]   dreq_strobe;
  logic [31:0]  dreq_data;
  logic         dresp_addr_ok;
  logic         dresp_data_ok;
  logic [31:0]  dresp_data;

  int n_cmp = 0;
  int n_err = 0;

  dmem_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .mread         (mread),
    .mwrite        (mwrite),
    .advance       (advance),
    .flush         (flush),
    .rd            (rd),
    .stall         (stall),
    .dreq_valid    (dreq_valid),
    .dreq_is_write (dreq_is_write),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simultaneous read and write requests are illegal stimulus
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(mread.valid && mwrite.valid)) else begin
        n_err++;
        $error("FAIL req_both: observed read+write valid, required at most one");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mread         = '0;
    mwrite        = '0;
    advance       = 1'b0;
    flush         = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
  endtask

  // Zero-wait load returning dat; leaves the bridge in DONE at the next negedge
  task automatic load0(input logic [31:0] addr, input logic [31:0] dat, input string tag);
    mread = '{valid: 1'b1, addr: addr, size: 3'd2};
    @(negedge clk);
    chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
    chk({tag, "_c0_vld"}, 32'(dreq_valid), 32'd0);
    nxt();
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = dat;
    @(negedge clk);
    chk({tag, "_c1_vld"}, 32'(dreq_valid), 32'd1);
    chk({tag, "_c1_stall"}, 32'(stall), 32'd1);
    chk({tag, "_c1_addr"}, dreq_addr, addr);
    chk({tag, "_c1_wr"}, 32'(dreq_is_write), 32'd0);
    chk({tag, "_c1_strb"}, 32'(dreq_strobe), 32'd0);
    chk({tag, "_c1_size"}, 32'(dreq_size), 32'd2);
    nxt();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rd", rd, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_vld", 32'(dreq_valid), 32'd0);
    chk("rst_addr", dreq_addr, 32'd0);
    chk("rst_data", dreq_data, 32'd0);
    chk("rst_misc", {25'd0, dreq_is_write, dreq_size, dreq_strobe}, 32'd0);
    nxt();

    // Load, zero-wait
    load0(32'h8000_1000, 32'hDEAD_BEEF, "ld");
    advance = 1'b1;
    @(negedge clk);
    chk("ld_done_stall", 32'(stall), 32'd0);
    chk("ld_done_rd", rd, 32'hDEAD_BEEF);
    chk("ld_done_vld", 32'(dreq_valid), 32'd0);
    nxt();
    clr();
    @(negedge clk);
    chk("ld_idle_stall", 32'(stall), 32'd0);
    chk("ld_idle_rd", rd, 32'd0);
    nxt();

    // Store, addr_ok in third ADDR cycle, data_ok two cycles later
    mwrite = '{valid: 1'b1, addr: 32'h8000_2002, size: 3'd1, data: 32'h1234_1234, strobe: 4'b1100};
    @(negedge clk);
    chk("st_c0_stall", 32'(stall), 32'd1);
    nxt();
    for (int i = 0; i < 3; i++) begin
      dresp_addr_ok = (i == 2);
      @(negedge clk);
      chk("st_a_vld", 32'(dreq_valid), 32'd1);
      chk("st_a_stall", 32'(stall), 32'd1);
      chk("st_a_addr", dreq_addr, 32'h8000_2002);
      chk("st_a_data", dreq_data, 32'h1234_1234);
      chk("st_a_misc", {25'd0, dreq_is_write, dreq_size, dreq_strobe}, {25'd0, 1'b1, 3'd1, 4'b1100});
      nxt();
    end
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    chk("st_d1_stall", 32'(stall), 32'd1);
    chk("st_d1_vld", 32'(dreq_valid), 32'd0);
    nxt();
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("st_d2_stall", 32'(stall), 32'd1);
    nxt();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    advance       = 1'b1;
    @(negedge clk);
    chk("st_done_stall", 32'(stall), 32'd0);
    chk("st_done_rd", rd, 32'd0);
    nxt();
    clr();

    // External freeze: DONE held four cycles with the request still present
    load0(32'h8000_3000, 32'hCAFE_F00D, "fz");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fz_rd", rd, 32'hCAFE_F00D);
      chk("fz_stall", 32'(stall), 32'd0);
      chk("fz_vld", 32'(dreq_valid), 32'd0);
      nxt();
    end
    advance = 1'b1;
    @(negedge clk);
    chk("fz_adv_rd", rd, 32'hCAFE_F00D);
    nxt();
    clr();
    @(negedge clk);
    chk("fz_idle_vld", 32'(dreq_valid), 32'd0);
    nxt();

    // Flush in first ADDR cycle; addr_ok two cycles later, data_ok one after
    mread = '{valid: 1'b1, addr: 32'h8000_4000, size: 3'd2};
    nxt();
    flush = 1'b1;
    @(negedge clk);
    chk("fa_a1_vld", 32'(dreq_valid), 32'd1);
    chk("fa_a1_stall", 32'(stall), 32'd1);
    nxt();
    clr();
    @(negedge clk);
    chk("fa_a2_vld", 32'(dreq_valid), 32'd1);
    chk("fa_a2_addr", dreq_addr, 32'h8000_4000);
    nxt();
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    chk("fa_a3_vld", 32'(dreq_valid), 32'd1);
    nxt();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("fa_drain_stall", 32'(stall), 32'd1);
    chk("fa_drain_vld", 32'(dreq_valid), 32'd0);
    chk("fa_drain_rd", rd, 32'd0);
    nxt();
    clr();
    @(negedge clk);
    chk("fa_idle_stall", 32'(stall), 32'd0);
    chk("fa_idle_rd", rd, 32'd0);
    chk("fa_idle_vld", 32'(dreq_valid), 32'd0);
    nxt();
    load0(32'h8000_5000, 32'h1122_3344, "fa_ld");
    advance = 1'b1;
    @(negedge clk);
    chk("fa_ld_rd", rd, 32'h1122_3344);
    chk("fa_ld_stall", 32'(stall), 32'd0);
    nxt();
    clr();

    // Flush in IDLE together with a request
    mread = '{valid: 1'b1, addr: 32'h8000_6000, size: 3'd2};
    flush = 1'b1;
    @(negedge clk);
    chk("fi_stall", 32'(stall), 32'd0);
    chk("fi_vld", 32'(dreq_valid), 32'd0);
    nxt();
    clr();
    @(negedge clk);
    chk("fi_next_vld", 32'(dreq_valid), 32'd0);
    chk("fi_next_stall", 32'(stall), 32'd0);
    nxt();

    // Reset while in DATA
    mread = '{valid: 1'b1, addr: 32'h8000_7000, size: 3'd2};
    nxt();
    dresp_addr_ok = 1'b1;
    nxt();
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    chk("rd_data_stall", 32'(stall), 32'd1);
    chk("rd_data_vld", 32'(dreq_valid), 32'd0);
    reset = 1'b1;
    clr();
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_stall", 32'(stall), 32'd0);
    chk("rmid_rd", rd, 32'd0);
    chk("rmid_vld", 32'(dreq_valid), 32'd0);
    chk("rmid_addr", dreq_addr, 32'd0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory responder for the MIPS pipeline's memory stage. It accepts the memory stage's `mem_read_req` / `mem_write_req` and returns the load word `rd`. It converts each access into exactly one transaction on the single-outstanding data bus (`dreq` / `dresp`) and stalls the pipeline until the response arrives. It holds the result stable while the pipeline is frozen by other hazards, so an access is never issued twice.

## Interface
Parameters: none (word_t = 32 bits, msize_t = 3 bits, strobe = 4 bits).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `mread`  in  mem_read_req  read request: `valid`, `addr[31:0]`, `size[2:0]`
- `mwrite`  in  mem_write_req  write request: `valid`, `addr[31:0]`, `size[2:0]`, `data[31:0]`, `strobe[3:0]`
- `advance`  in  1  memory-stage instruction moves to writeback this cycle
- `flush`  in  1  memory-stage instruction is killed (exception/eret)
- `rd`  out  32  load data for the current memory-stage instruction
- `stall`  out  1  hold the pipeline; memory access not yet complete
- `dreq_valid`  out  1  bus request valid
- `dreq_is_write`  out  1  1 = write, 0 = read
- `dreq_addr`  out  32  request address
- `dreq_size`  out  3  request size (passed through from `size`)
- `dreq_strobe`  out  4  byte enables; forced to 0 for reads
- `dreq_data`  out  32  write data
- `dresp_addr_ok`  in  1  request accepted this cycle
- `dresp_data_ok`  in  1  response/data valid this cycle
- `dresp_data`  in  32  read data

## Operation
- The request is `req = mread.valid | mwrite.valid`.
- `mread.valid` and `mwrite.valid` together is illegal. The bench asserts on it. The RTL gives the write priority.
- State machine states: IDLE, ADDR, DATA, DONE, DRAIN.
- **IDLE**
  - With `req & ~flush`: latch addr, size, data, strobe and is_write into request registers; go to ADDR.
  - With `req & flush`: no latch, stay in IDLE.
- **ADDR**
  - `dreq_valid = 1`. All `dreq_*` come from the request registers and stay stable until `dresp_addr_ok`.
  - On `addr_ok & data_ok`: capture `dresp_data` and go to DONE.
  - On `addr_ok` alone: go to DATA.
- **DATA**
  - On `data_ok`: capture `dresp_data` (reads only) and go to DONE.
- **DONE**
  - `rd` = captured data for a read; 0 for a write.
  - On `advance` or `flush`: go to IDLE.
  - Otherwise hold (pipeline frozen elsewhere) with no new bus request.
- **Flush while busy**
  - Flush in ADDR: `dreq_valid` stays asserted until `addr_ok` (no bus retraction), then go to DRAIN. If `data_ok` arrives in the same cycle as `addr_ok`, go directly to IDLE.
  - Flush in DATA: go to DRAIN.
  - A pending-flush flag records a flush seen in ADDR.
- **DRAIN**
  - Wait for `data_ok`, discard the data, go to IDLE.
  - Inputs are ignored in DRAIN.
- **Stall**
  - `stall = 1` in ADDR, DATA and DRAIN, and in IDLE when `req & ~flush`.
  - `stall = 0` in DONE, and in IDLE with no request.
- **Protocol**
  - `data_ok` before `addr_ok` never happens.
  - `data_ok` is ignored in IDLE and DONE.
  - There is at most one outstanding transaction.

## Timing
- **Reset**
  - State goes to IDLE; request registers and captured data are cleared to 0.
  - Outputs after reset: `rd = 0`, `stall = 0`, `dreq_valid = 0`, all other `dreq_* = 0`.
  - Reset mid-transaction abandons the transaction. The bus slave is reset by the same `reset`.
- **Best-case latency** (addr_ok and data_ok in the first ADDR cycle):
  - Cycle 0: IDLE sees the request; `stall = 1`.
  - Cycle 1: ADDR, `dreq_valid = 1`, responses arrive; `stall = 1`.
  - Cycle 2: DONE; `stall = 0`; `rd` valid.
  - Total: 2 stall cycles.
- Each extra cycle of `addr_ok` or `data_ok` delay adds one stall cycle.
- `rd` is registered and stable throughout DONE.
- Back-to-back accesses: `advance` in DONE at cycle N gives IDLE at N+1. If the next instruction carries a request at N+1, it enters ADDR at N+2.

## Test plan
- **Load, zero-wait:** `mread{valid=1, addr=0x80001000, size=2}`; slave returns addr_ok and data_ok in the first ADDR cycle with data 0xDEADBEEF. Required: `stall` high for exactly 2 cycles, one `dreq` with `is_write = 0`, `strobe = 0`, then `rd = 0xDEADBEEF`.
- **Store, delayed:** `mwrite{addr=0x80002002, size=1, data=0x12341234, strobe=4'b1100}`; addr_ok after 3 cycles, data_ok 2 cycles later. Required: `dreq` fields stable for all 3 cycles, `stall` high for 6 cycles, `rd = 0`.
- **External freeze:** `advance = 0` for 4 cycles in DONE after a load returns 0xCAFEF00D. Required: `rd` stays 0xCAFEF00D, no second `dreq_valid`, `stall = 0`.
- **Flush in ADDR:** flush asserted in the first ADDR cycle, addr_ok 2 cycles later, data_ok 1 cycle after that. Required: `dreq_valid` held until addr_ok, data discarded, `rd` remains 0, return to IDLE. A following load then completes with its own data.
- **Flush in IDLE:** `req` and `flush` asserted in the same cycle. Required: `dreq_valid` never rises, `stall = 0`.
- **Reset mid-DATA:** reset asserted in DATA. Required: next cycle IDLE, `stall = 0`, `rd = 0`, `dreq_valid = 0`.
